// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Handshake: mem_req stays high, with every other request field held stable,
// until the slave returns a one-cycle mem_ack; mem_rdata is valid only with mem_ack.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage: turns an ALU effective address into one req/ack bus access,
// stalls the core while it is outstanding and formats load data for writeback.
module load_store_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      stall,
    output logic                      done,
    output logic [31:0]               rdata,
    output logic                      addr_err,
    output logic                      bus_err,
    output logic [1:0]                state_dbg,
    load_store_unit_if.master         mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;

    logic              illegal;
    logic              misaligned;
    logic [3:0]        be_req;
    logic [31:0]       wdata_req;
    logic [31:0]       load_fmt;

    // Request decode; only meaningful while IDLE, the FSM gates its use.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (req_we) begin
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = (funct3 inside {3'b011, 3'b110, 3'b111});
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be_req    = 4'b1111;
        wdata_req = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_req    = 4'b0001 << addr[1:0];
                wdata_req = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_req    = 4'b0011 << addr[1:0];
                wdata_req = {2{wdata[15:0]}};
            end
            default: begin
                be_req    = 4'b1111;
                wdata_req = wdata;
            end
        endcase
    end

    // Lane and width come from the registered request, not the live core inputs.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = mem.mem_rdata[7:0];
        case (lane_q)
            2'd0:    byte_sel = mem.mem_rdata[7:0];
            2'd1:    byte_sel = mem.mem_rdata[15:8];
            2'd2:    byte_sel = mem.mem_rdata[23:16];
            default: byte_sel = mem.mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'd0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'd0, half_sel};
            default: load_fmt = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        stall       = 1'b0;
        done        = 1'b0;
        addr_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                addr_err = req_valid & (illegal | misaligned);
                if (req_valid && !addr_err) begin
                    stall       = 1'b1;
                    state_d     = ST_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_we;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = be_req;
                    mem_wdata_d = wdata_req;
                    cnt_d       = '0;
                    f3_d        = funct3;
                    lane_d      = addr[1:0];
                end
            end

            ST_WAIT: begin
                stall = 1'b1;
                // An ack arriving on the last timeout cycle still completes normally.
                if (mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = load_fmt;
                    end
                    state_d = ST_DONE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
            f3_q        <= '0;
            lane_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign rdata         = rdata_q;
    assign bus_err       = bus_err_q;
    assign state_dbg     = state_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the ALU. It consumes the ALU result as the effective address, plus rs2 store data and funct3.
- Drives a simple req/ack data-memory bus with byte enables. Formats load data (sign/zero extension) for register-file writeback.
- Stalls the single-cycle core while an access is outstanding. Flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, cycles in WAIT without mem_ack before bus_err is raised; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  current instruction is a load/store; held stable by core while stall=1
- req_we  input  1  1=store, 0=load
- funct3  input  3  RV32I width/sign code (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010)
- addr  input  32  effective address (ALU result)
- wdata  input  32  store data (rs2)
- stall  output  1  core must hold PC/instruction this cycle
- done  output  1  one-cycle pulse: access completed (or timed out)
- rdata  output  32  formatted load result, valid when done=1 for a load
- addr_err  output  1  combinational: request misaligned or illegal funct3
- bus_err  output  1  one-cycle pulse with done when access timed out
- mem_req  output  1  bus request, registered
- mem_we  output  1  bus write strobe, registered
- mem_addr  output  32  word address {addr[31:2],2'b00}, registered
- mem_be  output  4  byte enables, registered
- mem_wdata  output  32  lane-replicated store data, registered
- mem_ack  input  1  bus completion, single-cycle pulse
- mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Reset (async, any state): state=IDLE, mem_req/mem_we/done/bus_err=0, mem_addr/mem_be/mem_wdata/rdata=0, counter=0. A reset taken in WAIT drops mem_req immediately; any later ack is ignored.
- States: IDLE, WAIT, DONE.
- Error check (combinational, IDLE only):
  - addr_err=req_valid & (illegal | misaligned).
  - illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
  - misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - On addr_err the unit issues no bus access and stays in IDLE; stall=0; addr_err is 0 outside IDLE.
- IDLE with req_valid & ~addr_err:
  - stall=1. Next edge: register mem_addr, mem_we=req_we, mem_be, mem_wdata; set mem_req=1, counter=0; go to WAIT.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
  - loads drive mem_be the same way.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- WAIT:
  - stall=1; mem_req and all mem_* outputs held constant; counter increments each cycle.
  - On mem_ack: mem_req=0 next edge; loads latch formatted mem_rdata into rdata; go to DONE.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with no ack: mem_req=0, rdata unchanged, bus_err=1 in DONE; go to DONE.
  - mem_ack on the same cycle as the timeout: the ack wins, no bus_err.
- DONE:
  - done=1, stall=0 (core retires instruction this cycle); next edge go to IDLE.
  - req_valid is ignored in DONE; the next instruction is sampled in the following IDLE cycle.
- Load formatting, with lane=addr[1:0] of the registered request:
  - LB: sign-extend byte[lane]
  - LBU: zero-extend byte[lane]
  - LH: sign-extend half[addr[1]]
  - LHU: zero-extend half[addr[1]]
  - LW: full word
- rdata holds its value until the next successful load; stores never change rdata.
- mem_ack received in IDLE or DONE is ignored.
- Throughput: minimum access = 3 cycles (IDLE→WAIT with ack in the first WAIT cycle→DONE).

Test Plan:
- Reset mid-WAIT: rst_n low while mem_req=1 → mem_req=0 immediately, state IDLE; ack pulsed afterward produces no done.
- LB addr=0x1003, mem_rdata=0x80FF_1234, ack after 2 WAIT cycles → mem_addr=0x1000, mem_be=1000, done pulse, rdata=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr=0x2002, wdata=0xDEAD_BEEF → mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF; rdata unchanged; stall high until DONE.
- LW addr=0x3001 → addr_err=1 same cycle, stall=0, mem_req never asserts. funct3=011 load at aligned address → addr_err=1.
- TIMEOUT=16, no ack → bus_err and done pulse together exactly 16 WAIT cycles after mem_req rises; mem_req=0. Ack on cycle 16 instead → done without bus_err.
- Back-to-back LW 0x10 then SW 0x14: each completes in 3 cycles with ack after 1 WAIT cycle, with no dropped or duplicated request. A stray mem_ack in DONE is ignored.
